// File: rtl/rename_pkg.sv
// rename_pkg: shared types and constants for decode_rename.
// Optional macro FREE_COUNT_PORT_EN is handled in decode_rename_if/decode_rename.
package rename_pkg;

  localparam int NUM_AREGS = 32;
  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = 6;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_XOR  = 3'd3,
    OP_ANDI = 3'd4,
    OP_SRA  = 3'd5,
    OP_LW   = 3'd6,
    OP_SW   = 3'd7
  } op_e;

  typedef struct packed {
    logic [6:0]        opcode;
    op_e               op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic              has_rd;
    logic              illegal;
  } ren_t;

endpackage

// File: rtl/decode_rename_if.sv
// decode_rename_if: fetch/retire inputs and dispatch outputs of decode_rename.
// FREE_COUNT_PORT_EN adds the free_count signal.
interface decode_rename_if;
  import rename_pkg::*;

  logic              in_valid;
  logic [31:0]       instr;
  logic              in_ready;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              out_valid;
  logic [6:0]        opcode;
  logic [2:0]        op;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic [PREG_W-1:0] ps1;
  logic [PREG_W-1:0] ps2;
  logic [PREG_W-1:0] pd;
  logic [PREG_W-1:0] old_pd;
  logic              has_rd;
  logic              illegal;
`ifdef FREE_COUNT_PORT_EN
  logic [6:0]        free_count;
`endif

  modport master (
    output in_valid, instr, free_valid, free_preg,
    input  in_ready, out_valid, opcode, op,
    input  rs1, rs2, rd, imm,
    input  ps1, ps2, pd, old_pd,
`ifdef FREE_COUNT_PORT_EN
    input  free_count,
`endif
    input  has_rd, illegal
  );

  modport slave (
    input  in_valid, instr, free_valid, free_preg,
    output in_ready, out_valid, opcode, op,
    output rs1, rs2, rd, imm,
    output ps1, ps2, pd, old_pd,
`ifdef FREE_COUNT_PORT_EN
    output free_count,
`endif
    output has_rd, illegal
  );

endinterface

// File: rtl/rename_free_list.sv
// rename_free_list: 32-entry circular FIFO of free physical tags.
// Resets holding tags 32..63; a push into a full list is dropped.
module rename_free_list
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pop,
  input  logic              push,
  input  logic [PREG_W-1:0] push_tag,
  output logic [PREG_W-1:0] head_tag,
  output logic [6:0]        count
);

  logic [PREG_W-1:0] mem [32];
  logic [4:0]        head;
  logic [4:0]        tail;
  logic              push_ok;

  assign push_ok  = push && (count != 7'd32);
  assign head_tag = mem[head];

  // Storage, pointers and occupancy; pop and push may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= PREG_W'(32 + i);
      head  <= '0;
      tail  <= '0;
      count <= 7'd32;
    end else begin
      if (push_ok) begin
        mem[tail] <= push_tag;
        tail      <= tail + 5'd1;
      end
      if (pop)
        head <= head + 5'd1;
      count <= count + {6'd0, push_ok} - {6'd0, pop};
    end
  end

endmodule

// File: rtl/decode_rename.sv
// decode_rename: RV32 subset decode plus RAT rename with free list.
// Define FREE_COUNT_PORT_EN to expose the free-list count on the bus.
module decode_rename
  import rename_pkg::*;
(
  input logic           clk,
  input logic           rst,
  decode_rename_if.slave bus
);

  logic [PREG_W-1:0] rat [NUM_AREGS];
  logic [PREG_W-1:0] head_tag;
  logic [6:0]        count;
  logic              accept;
  logic              legal;
  logic              wr;
  op_e               op;
  logic [31:0]       imm;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       i_imm;
  logic [31:0]       s_imm;
  ren_t              nxt;
  ren_t              q;
  logic              out_v;

  assign opc   = bus.instr[6:0];
  assign rd    = bus.instr[11:7];
  assign f3    = bus.instr[14:12];
  assign rs1   = bus.instr[19:15];
  assign rs2   = bus.instr[24:20];
  assign f7    = bus.instr[31:25];
  assign i_imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign s_imm = {{20{bus.instr[31]}}, f7, rd};

  assign bus.in_ready = (count != 7'd0);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr           = legal && (op != OP_SW) && (rd != 5'd0);

  // Classify the instruction and pick its immediate.
  always_comb begin
    legal = 1'b0;
    op    = OP_ADD;
    imm   = '0;
    unique case (1'b1)
      (opc == OPC_R && f7 == 7'h00 && f3 == 3'b000): begin
        legal = 1'b1; op = OP_ADD;
      end
      (opc == OPC_R && f7 == 7'h20 && f3 == 3'b000): begin
        legal = 1'b1; op = OP_SUB;
      end
      (opc == OPC_R && f7 == 7'h00 && f3 == 3'b100): begin
        legal = 1'b1; op = OP_XOR;
      end
      (opc == OPC_R && f7 == 7'h20 && f3 == 3'b101): begin
        legal = 1'b1; op = OP_SRA;
      end
      (opc == OPC_I && f3 == 3'b000): begin
        legal = 1'b1; op = OP_ADDI; imm = i_imm;
      end
      (opc == OPC_I && f3 == 3'b111): begin
        legal = 1'b1; op = OP_ANDI; imm = i_imm;
      end
      (opc == OPC_LW && f3 == 3'b010): begin
        legal = 1'b1; op = OP_LW; imm = i_imm;
      end
      (opc == OPC_SW && f3 == 3'b010): begin
        legal = 1'b1; op = OP_SW; imm = s_imm;
      end
      default: ;
    endcase
  end

  // Sources read the RAT before this instruction's own update.
  always_comb begin
    nxt         = '0;
    nxt.opcode  = opc;
    nxt.op      = op;
    nxt.rs1     = rs1;
    nxt.rs2     = rs2;
    nxt.rd      = rd;
    nxt.imm     = imm;
    nxt.ps1     = rat[rs1];
    nxt.ps2     = rat[rs2];
    nxt.has_rd  = wr;
    nxt.illegal = !legal;
    if (wr) begin
      nxt.pd     = head_tag;
      nxt.old_pd = rat[rd];
    end
  end

  rename_free_list u_fl (
    .clk      (clk),
    .rst      (rst),
    .pop      (accept && wr),
    .push     (bus.free_valid),
    .push_tag (bus.free_preg),
    .head_tag (head_tag),
    .count    (count)
  );

  // RAT: identity at reset; x0 is never written since wr needs rd != 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++)
        rat[i] <= PREG_W'(i);
    end else if (accept && wr) begin
      rat[rd] <= head_tag;
    end
  end

  // Output register; valid pulses for one cycle per accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= 1'b0;
      q     <= '0;
    end else begin
      out_v <= accept;
      if (accept)
        q <= nxt;
    end
  end

  assign bus.out_valid = out_v;
  assign bus.opcode    = q.opcode;
  assign bus.op        = q.op;
  assign bus.rs1       = q.rs1;
  assign bus.rs2       = q.rs2;
  assign bus.rd        = q.rd;
  assign bus.imm       = q.imm;
  assign bus.ps1       = q.ps1;
  assign bus.ps2       = q.ps2;
  assign bus.pd        = q.pd;
  assign bus.old_pd    = q.old_pd;
  assign bus.has_rd    = q.has_rd;
  assign bus.illegal   = q.illegal;
`ifdef FREE_COUNT_PORT_EN
  assign bus.free_count = count;
`endif

endmodule

// File: tb/tb_decode_rename.sv
// tb_decode_rename: directed plan plus random stream checked
// against an array/queue reference of the RAT and free list.
module tb_decode_rename;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_rename_if bus();

  decode_rename dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int rat_m [32];
  int free_q [$];

  bit          pend_v;
  bit          e_legal;
  bit          e_has;
  int          e_op;
  int          e_pd;
  int          e_old;
  int          e_ps1;
  int          e_ps2;
  logic [31:0] e_imm;
  logic [31:0] e_w;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat_m[i] = i;
    free_q.delete();
    for (int i = 32; i < 64; i++) free_q.push_back(i);
    pend_v = 1'b0;
  endtask

  task automatic model_rename(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int rd;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    rd  = int'(w[11:7]);
    e_w = w;
    e_legal = 1'b1;
    if      (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) e_op = 0;
    else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) e_op = 1;
    else if (opc == 7'h13 && f3 == 3'd0)                e_op = 2;
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd4) e_op = 3;
    else if (opc == 7'h13 && f3 == 3'd7)                e_op = 4;
    else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd5) e_op = 5;
    else if (opc == 7'h03 && f3 == 3'd2)                e_op = 6;
    else if (opc == 7'h23 && f3 == 3'd2)                e_op = 7;
    else begin
      e_legal = 1'b0;
      e_op = 0;
    end
    e_imm = 32'd0;
    if (e_op == 2 || e_op == 4 || e_op == 6)
      e_imm = {{20{w[31]}}, w[31:20]};
    if (e_op == 7)
      e_imm = {{20{w[31]}}, w[31:25], w[11:7]};
    e_ps1 = rat_m[w[19:15]];
    e_ps2 = rat_m[w[24:20]];
    e_has = e_legal && e_op != 7 && rd != 0;
    e_pd  = 0;
    e_old = 0;
    if (e_has) begin
      e_pd  = free_q.pop_front();
      e_old = rat_m[rd];
      rat_m[rd] = e_pd;
    end
  endtask

  task automatic compare_pending();
    check("out_valid", bus.out_valid, pend_v);
    if (pend_v) begin
      check("opcode", bus.opcode, e_w[6:0]);
      check("rs1", bus.rs1, e_w[19:15]);
      check("rs2", bus.rs2, e_w[24:20]);
      check("rd", bus.rd, e_w[11:7]);
      check("illegal", bus.illegal, !e_legal);
      check("op", bus.op, e_op);
      check("has_rd", bus.has_rd, e_has);
      check("pd", bus.pd, e_pd);
      check("old_pd", bus.old_pd, e_old);
      if (e_legal) begin
        check("imm", bus.imm, e_imm);
        check("ps1", bus.ps1, e_ps1);
        check("ps2", bus.ps2, e_ps2);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] w,
                       input bit fv, input logic [5:0] fp);
    int sz0;
    bit rdy;
    @(negedge clk);
    compare_pending();
    sz0 = free_q.size();
    rdy = (sz0 != 0);
    check("in_ready", bus.in_ready, rdy);
`ifdef FREE_COUNT_PORT_EN
    check("free_count", bus.free_count, sz0);
`endif
    bus.in_valid   = v;
    bus.instr      = w;
    bus.free_valid = fv;
    bus.free_preg  = fp;
    pend_v = v && rdy;
    if (pend_v) model_rename(w);
    if (fv && sz0 < 32) free_q.push_back(int'(fp));
  endtask

  task automatic look();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_pending();
    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.free_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_pd", bus.pd, 6'd0);
    check("rst_op", bus.op, 3'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  d;
    logic [11:0] im;
    int k;
    a  = 5'($urandom);
    b  = 5'($urandom);
    d  = 5'($urandom);
    im = 12'($urandom);
    k  = $urandom_range(0, 9);
    case (k)
      0: return {7'h00, b, a, 3'd0, d, 7'h33};
      1: return {7'h20, b, a, 3'd0, d, 7'h33};
      2: return {7'h00, b, a, 3'd4, d, 7'h33};
      3: return {7'h20, b, a, 3'd5, d, 7'h33};
      4: return {im, a, 3'd0, d, 7'h13};
      5: return {im, a, 3'd7, d, 7'h13};
      6: return {im, a, 3'd2, d, 7'h03};
      7: return {im[11:5], b, a, 3'd2, im[4:0], 7'h23};
      8: return {7'h00, b, a, 3'd1, d, 7'h33};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.in_valid   = 1'b0;
    bus.instr      = '0;
    bus.free_valid = 1'b0;
    bus.free_preg  = '0;
    model_reset();
    do_reset();

    drive(1, 32'h002081B3, 0, 0); look();
    check("tp_add_op", bus.op, 3'd0);
    check("tp_add_ps1", bus.ps1, 6'd1);
    check("tp_add_ps2", bus.ps2, 6'd2);
    check("tp_add_pd", bus.pd, 6'd32);
    check("tp_add_old", bus.old_pd, 6'd3);
    check("tp_add_hasrd", bus.has_rd, 1'b1);

    drive(1, 32'h40318233, 0, 0); look();
    check("tp_sub_op", bus.op, 3'd1);
    check("tp_sub_ps1", bus.ps1, 6'd32);
    check("tp_sub_ps2", bus.ps2, 6'd32);
    check("tp_sub_pd", bus.pd, 6'd33);
    check("tp_sub_old", bus.old_pd, 6'd4);

    drive(1, 32'hFFF00293, 0, 0); look();
    check("tp_addi_op", bus.op, 3'd2);
    check("tp_addi_imm", bus.imm, 32'hFFFF_FFFF);
    check("tp_addi_ps1", bus.ps1, 6'd0);
    check("tp_addi_pd", bus.pd, 6'd34);

    drive(1, 32'h0020A423, 0, 0); look();
    check("tp_sw_op", bus.op, 3'd7);
    check("tp_sw_imm", bus.imm, 32'd8);
    check("tp_sw_hasrd", bus.has_rd, 1'b0);
    check("tp_sw_pd", bus.pd, 6'd0);

    drive(1, 32'h00000000, 0, 0); look();
    check("tp_ill", bus.illegal, 1'b1);
    check("tp_ill_valid", bus.out_valid, 1'b1);
    check("tp_ill_hasrd", bus.has_rd, 1'b0);

    drive(1, 32'h002081B3, 0, 0); look();
    check("tp_add2_pd", bus.pd, 6'd35);
    check("tp_add2_old", bus.old_pd, 6'd32);

    do_reset();
    drive(1, 32'h002081B3, 0, 0); look();
    check("tp_rst_ps1", bus.ps1, 6'd1);
    check("tp_rst_ps2", bus.ps2, 6'd2);
    check("tp_rst_pd", bus.pd, 6'd32);

    do_reset();
    for (int i = 0; i < 32; i++) drive(1, 32'h00100093, 0, 0);
    look();
    check("tp_empty_ready", bus.in_ready, 1'b0);
    drive(1, 32'h0020A423, 0, 0); look();
    check("tp_empty_sw", bus.out_valid, 1'b0);
    drive(0, 32'h0, 1, 6'd7); look();
    check("tp_refill_ready", bus.in_ready, 1'b1);
    drive(1, 32'h00100093, 0, 0); look();
    check("tp_refill_pd", bus.pd, 6'd7);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drive($urandom_range(0, 4) != 0, rnd_instr(),
            $urandom_range(0, 2) == 0, 6'($urandom));
    end
    drive(0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
